// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle for the seven-segment scan decoder: the scanned display lines
// coming in and the decoded word/status going out.
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_i;
    logic [DIGITS-1:0]   dig_sel_i;
    logic [4*DIGITS-1:0] value_o;
    logic                valid_o;
    logic                err_o;
    logic [DIGITS-1:0]   cap_mask_o;

    modport master (
        output seg_i,
        output dig_sel_i,
        input  value_o,
        input  valid_o,
        input  err_o,
        input  cap_mask_o
    );

    modport slave (
        input  seg_i,
        input  dig_sel_i,
        output value_o,
        output valid_o,
        output err_o,
        output cap_mask_o
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers the binary digit word from a scanned seven-segment bus. A pattern is
// accepted once per dwell after it holds stable; a full set of digits publishes a word.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_decoder_if.slave   bus
);

    localparam int                CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]     CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [DIGITS-1:0] ALL_DIGS = '1;

    // Returns {legal, value}; a blank display is a legal zero.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = 5'h10;
            7'h06:   res = 5'h11;
            7'h5B:   res = 5'h12;
            7'h4F:   res = 5'h13;
            7'h66:   res = 5'h14;
            7'h6D:   res = 5'h15;
            7'h7D:   res = 5'h16;
            7'h07:   res = 5'h17;
            7'h7F:   res = 5'h18;
            7'h6F:   res = 5'h19;
            7'h00:   res = 5'h10;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    logic [6:0]          prev_seg_q,   prev_seg_d;
    logic [DIGITS-1:0]   prev_sel_q,   prev_sel_d;
    logic [CW-1:0]       cnt_q,        cnt_d;
    logic                acc_q,        acc_d;
    logic [4*DIGITS-1:0] shadow_q,     shadow_d;
    logic [DIGITS-1:0]   cap_mask_q,   cap_mask_d;
    logic [4*DIGITS-1:0] value_q,      value_d;
    logic                valid_q,      valid_d;
    logic                err_q,        err_d;

    logic                sel_onehot;
    logic                pair_same;
    logic [4:0]          decoded;
    logic [DIGITS-1:0]   mask_next;

    // Stability filter: the accept is registered so the accepted pair is the
    // one still held in prev_*_q during the cycle acc_q is high.
    always_comb begin
        sel_onehot = $onehot(bus.dig_sel_i);
        pair_same  = (bus.seg_i == prev_seg_q) && (bus.dig_sel_i == prev_sel_q);
        prev_seg_d = bus.seg_i;
        prev_sel_d = bus.dig_sel_i;

        cnt_d = '0;
        if (sel_onehot && pair_same) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
        end else if (sel_onehot) begin
            cnt_d = CW'(1);
        end

        acc_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
    end

    // Frame assembly on a registered accept.
    always_comb begin
        decoded    = decode_seg(prev_seg_q);
        mask_next  = cap_mask_q | prev_sel_q;
        shadow_d   = shadow_q;
        cap_mask_d = cap_mask_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (acc_q) begin
            if (decoded[4]) begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (prev_sel_q[k]) begin
                        shadow_d[4*k +: 4] = decoded[3:0];
                    end
                end
                if (mask_next == ALL_DIGS) begin
                    value_d    = shadow_d;
                    valid_d    = 1'b1;
                    cap_mask_d = '0;
                end else begin
                    cap_mask_d = mask_next;
                end
            end else begin
                err_d      = 1'b1;
                cap_mask_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_seg_q <= '0;
            prev_sel_q <= '0;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            shadow_q   <= '0;
            cap_mask_q <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_seg_q <= prev_seg_d;
            prev_sel_q <= prev_sel_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            shadow_q   <= shadow_d;
            cap_mask_q <= cap_mask_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.value_o    = value_q;
    assign bus.valid_o    = valid_q;
    assign bus.err_o      = err_q;
    assign bus.cap_mask_o = cap_mask_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random scans, checked
// against a run-length based reference model of the display bus.
module tb_seg7_scan_decoder;

    localparam int D = 4;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.DIGITS(D)) bus ();

    seg7_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int model_decode(input logic [6:0] s);
        if (s == 7'h00) return 0;
        for (int i = 0; i < 10; i++) if (seg_tab[i] == s) return i;
        return -1;
    endfunction

    // ---------------- reference model ----------------
    int            m_run;
    logic [6:0]    m_last_seg;
    logic [D-1:0]  m_last_sel;
    bit            m_pend;
    logic [6:0]    m_pseg;
    logic [D-1:0]  m_psel;
    int            m_shadow [D];
    bit            m_have [D];
    logic [4*D-1:0] exp_value;
    logic [D-1:0]  exp_mask;
    bit            exp_valid, exp_err;
    int            m_valid_cnt = 0;
    int            m_err_cnt   = 0;

    always @(posedge clk) begin
        int  k, v;
        bit  all;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (rst) begin
            m_run = 0; m_last_seg = '0; m_last_sel = '0; m_pend = 0;
            for (int i = 0; i < D; i++) begin m_shadow[i] = 0; m_have[i] = 0; end
            exp_value = '0;
        end else begin
            if (m_pend) begin
                k = 0;
                for (int i = 0; i < D; i++) if (m_psel[i]) k = i;
                v = model_decode(m_pseg);
                if (v >= 0) begin
                    m_shadow[k] = v;
                    m_have[k]   = 1;
                    all = 1;
                    for (int i = 0; i < D; i++) if (!m_have[i]) all = 0;
                    if (all) begin
                        for (int i = 0; i < D; i++) exp_value[4*i +: 4] = 4'(m_shadow[i]);
                        exp_valid = 1'b1;
                        m_valid_cnt++;
                        for (int i = 0; i < D; i++) m_have[i] = 0;
                    end
                end else begin
                    exp_err = 1'b1;
                    m_err_cnt++;
                    for (int i = 0; i < D; i++) m_have[i] = 0;
                end
            end
            if ($countones(bus.dig_sel_i) == 1 && bus.dig_sel_i == m_last_sel && bus.seg_i == m_last_seg)
                m_run++;
            else
                m_run = ($countones(bus.dig_sel_i) == 1) ? 1 : 0;
            m_pend     = (m_run == S);
            m_pseg     = bus.seg_i;
            m_psel     = bus.dig_sel_i;
            m_last_seg = bus.seg_i;
            m_last_sel = bus.dig_sel_i;
        end
        for (int i = 0; i < D; i++) exp_mask[i] = m_have[i];
    end

    // ---------------- per-cycle monitor ----------------
    bit             chk_en = 0;
    int             n_valid = 0;
    int             n_err   = 0;
    logic [4*D-1:0] last_value = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (bus.value_o !== exp_value) begin
                n_fail++;
                $display("FAIL mon_value t=%0t got=%h exp=%h", $time, bus.value_o, exp_value);
            end
            n_checks++;
            if (bus.valid_o !== exp_valid) begin
                n_fail++;
                $display("FAIL mon_valid t=%0t got=%b exp=%b", $time, bus.valid_o, exp_valid);
            end
            n_checks++;
            if (bus.err_o !== exp_err) begin
                n_fail++;
                $display("FAIL mon_err t=%0t got=%b exp=%b", $time, bus.err_o, exp_err);
            end
            n_checks++;
            if (bus.cap_mask_o !== exp_mask) begin
                n_fail++;
                $display("FAIL mon_mask t=%0t got=%b exp=%b", $time, bus.cap_mask_o, exp_mask);
            end
            n_checks++;
            if (bus.valid_o === 1'b1 && bus.err_o === 1'b1) begin
                n_fail++;
                $display("FAIL mon_valid_err_overlap t=%0t got=11 exp=not both", $time);
            end
            if (bus.valid_o === 1'b1) begin n_valid++; last_value = bus.value_o; end
            if (bus.err_o === 1'b1) n_err++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [D-1:0] sel, input logic [6:0] seg, input int n);
        bus.dig_sel_i = sel;
        bus.seg_i     = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hold('0, 7'h00, 2);
        rst = 1'b0;
        n_checks++;
        if (bus.value_o !== 16'h0) begin n_fail++; $display("FAIL reset_value got=%h exp=0000", bus.value_o); end
        n_checks++;
        if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
        n_checks++;
        if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
        n_checks++;
        if (bus.cap_mask_o !== 4'b0000) begin n_fail++; $display("FAIL reset_mask got=%b exp=0000", bus.cap_mask_o); end
        chk_en = 1;
    endtask

    task automatic test_full_scan();
        int v0 = n_valid, e0 = n_err;
        hold(4'b0001, 7'h6F, 6);
        hold(4'b0010, 7'h07, 6);
        hold(4'b0100, 7'h4F, 6);
        hold(4'b1000, 7'h06, 6);
        hold(4'b0000, 7'h00, 3);
        n_checks++;
        if (n_valid - v0 != 1) begin n_fail++; $display("FAIL scan_valid_count got=%0d exp=1", n_valid - v0); end
        n_checks++;
        if (last_value !== 16'h1379) begin n_fail++; $display("FAIL scan_value got=%h exp=1379", last_value); end
        n_checks++;
        if (bus.cap_mask_o !== 4'b0000) begin n_fail++; $display("FAIL scan_mask got=%b exp=0000", bus.cap_mask_o); end
        n_checks++;
        if (n_err != e0) begin n_fail++; $display("FAIL scan_err_count got=%0d exp=0", n_err - e0); end
    endtask

    task automatic test_short_dwell();
        int v0 = n_valid, e0 = n_err;
        hold(4'b0001, 7'h3F, 3);
        hold(4'b0001, 7'h3F, 0);
        n_checks++;
        if (bus.cap_mask_o !== 4'b0000) begin n_fail++; $display("FAIL short_no_accept got=%b exp=0000", bus.cap_mask_o); end
        hold(4'b0001, 7'h06, 4);
        hold(4'b0000, 7'h00, 3);
        n_checks++;
        if (bus.cap_mask_o !== 4'b0001) begin n_fail++; $display("FAIL short_mask got=%b exp=0001", bus.cap_mask_o); end
        n_checks++;
        if (n_valid != v0 || n_err != e0) begin
            n_fail++; $display("FAIL short_pulses got=%0d/%0d exp=0/0", n_valid - v0, n_err - e0);
        end
    endtask

    task automatic test_illegal();
        int v0 = n_valid, e0 = n_err;
        logic [4*D-1:0] want;
        int dig [D];
        hold(4'b0100, 7'h77, 4);
        hold(4'b0000, 7'h00, 2);
        n_checks++;
        if (n_err - e0 != 1) begin n_fail++; $display("FAIL illegal_err_count got=%0d exp=1", n_err - e0); end
        n_checks++;
        if (bus.cap_mask_o !== 4'b0000) begin n_fail++; $display("FAIL illegal_mask got=%b exp=0000", bus.cap_mask_o); end
        n_checks++;
        if (bus.value_o !== 16'h1379) begin n_fail++; $display("FAIL illegal_value_hold got=%h exp=1379", bus.value_o); end
        n_checks++;
        if (n_valid != v0) begin n_fail++; $display("FAIL illegal_no_valid got=%0d exp=0", n_valid - v0); end
        want = '0;
        for (int i = 0; i < D; i++) begin
            dig[i] = $urandom_range(0, 9);
            want[4*i +: 4] = 4'(dig[i]);
        end
        for (int j = 0; j < D; j++) begin
            int i = (j + 2) % D;
            hold(4'(1 << i), seg_tab[dig[i]], 5);
        end
        hold(4'b0000, 7'h00, 2);
        n_checks++;
        if (n_valid - v0 != 1) begin n_fail++; $display("FAIL rescan_valid_count got=%0d exp=1", n_valid - v0); end
        n_checks++;
        if (last_value !== want) begin n_fail++; $display("FAIL rescan_value got=%h exp=%h", last_value, want); end
    endtask

    task automatic test_bad_select();
        int v0 = n_valid, e0 = n_err;
        hold(4'b0001, 7'h3F, 5);
        hold(4'b0000, 7'h7F, 20);
        hold(4'b0011, 7'h7F, 20);
        hold(4'b0000, 7'h00, 2);
        n_checks++;
        if (bus.cap_mask_o !== 4'b0001) begin n_fail++; $display("FAIL badsel_mask got=%b exp=0001", bus.cap_mask_o); end
        n_checks++;
        if (n_valid != v0 || n_err != e0) begin
            n_fail++; $display("FAIL badsel_pulses got=%0d/%0d exp=0/0", n_valid - v0, n_err - e0);
        end
    endtask

    task automatic test_blanks();
        int v0 = n_valid;
        for (int r = 0; r < 2; r++) begin
            hold(4'b0001, 7'h00, 5);
            hold(4'b0010, 7'h00, 5);
            hold(4'b0100, 7'h5B, 5);
            hold(4'b1000, 7'h7D, 5);
            hold(4'b0000, 7'h00, 2);
            n_checks++;
            if (last_value !== 16'h6200) begin n_fail++; $display("FAIL blank_value pass=%0d got=%h exp=6200", r, last_value); end
        end
        n_checks++;
        if (n_valid - v0 != 2) begin n_fail++; $display("FAIL blank_valid_count got=%0d exp=2", n_valid - v0); end
    endtask

    task automatic test_reset_midframe();
        int v0;
        hold(4'b0001, 7'h3F, 5);
        hold(4'b0010, 7'h06, 5);
        hold(4'b0100, 7'h5B, 5);
        n_checks++;
        if (bus.cap_mask_o !== 4'b0111) begin n_fail++; $display("FAIL midrst_pre_mask got=%b exp=0111", bus.cap_mask_o); end
        rst = 1'b1;
        hold(4'b0000, 7'h00, 1);
        rst = 1'b0;
        n_checks++;
        if (bus.value_o !== 16'h0 || bus.valid_o !== 1'b0 || bus.err_o !== 1'b0 || bus.cap_mask_o !== 4'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs got=%h/%b/%b/%b exp=0000/0/0/0",
                     bus.value_o, bus.valid_o, bus.err_o, bus.cap_mask_o);
        end
        v0 = n_valid;
        hold(4'b1000, 7'h06, 6);
        hold(4'b0000, 7'h00, 2);
        n_checks++;
        if (n_valid != v0) begin n_fail++; $display("FAIL midrst_no_valid got=%0d exp=0", n_valid - v0); end
        n_checks++;
        if (bus.cap_mask_o !== 4'b1000) begin n_fail++; $display("FAIL midrst_mask got=%b exp=1000", bus.cap_mask_o); end
    endtask

    task automatic test_random();
        logic [D-1:0] sel;
        logic [6:0]   seg;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 5) == 0) sel = 4'($urandom_range(0, 15));
            else                           sel = 4'(1 << $urandom_range(0, D - 1));
            if ($urandom_range(0, 7) == 0)       seg = 7'($urandom_range(0, 127));
            else if ($urandom_range(0, 10) == 0) seg = 7'h00;
            else                                 seg = seg_tab[$urandom_range(0, 9)];
            hold(sel, seg, $urandom_range(1, 7));
        end
        hold(4'b0000, 7'h00, 3);
        n_checks++;
        if (n_valid != m_valid_cnt) begin n_fail++; $display("FAIL rand_valid_count got=%0d exp=%0d", n_valid, m_valid_cnt); end
        n_checks++;
        if (n_err != m_err_cnt) begin n_fail++; $display("FAIL rand_err_count got=%0d exp=%0d", n_err, m_err_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        bus.seg_i     = '0;
        bus.dig_sel_i = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_full_scan();
        test_short_dwell();
        test_illegal();
        test_bad_select();
        test_blanks();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Decodes a scanned, multiplexed seven-segment display bus back into a binary digit word.
- Watches the per-digit segment lines and one-hot digit select, and accepts a pattern only after it has held stable long enough.
- Maps each accepted pattern back to its 4-bit digit value and assembles a full multi-digit word, published with a one-cycle valid pulse.
- Used as a loopback checker and readback path beside the display driver.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive identical cycles required to accept a pattern (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
seg_i  input  7  segment lines; bit0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g; active-high
dig_sel_i  input  DIGITS  one-hot digit select; bit k = digit k (digit 0 = least significant nibble)
value_o  output  4*DIGITS  last complete decoded word
valid_o  output  1  one-cycle pulse: value_o updated this cycle
err_o  output  1  one-cycle pulse: illegal pattern accepted, frame discarded
cap_mask_o  output  DIGITS  digits captured so far in the current frame

Behaviour:
- Reset (rst=1 at a clk edge): value_o=0, valid_o=0, err_o=0, cap_mask_o=0. Stability counter and shadow register clear. Reset asserted mid-frame discards the partial frame.

Legal pattern table (seg_i hex -> digit):
- 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9.
- 00 (blank) -> 0.
- Every other pattern is illegal.

Stability filter:
- Register the previous (seg_i, dig_sel_i) pair.
- Counter increments, saturating at STABLE_CYCLES, while the pair equals the previous cycle's pair and dig_sel_i is one-hot. Otherwise the counter loads 1 if dig_sel_i is one-hot, else 0.
- Accept fires in exactly the cycle the counter transitions to STABLE_CYCLES. This is once per dwell; no re-accept while held.
- dig_sel_i that is zero or multi-hot never accepts and does not affect cap_mask_o.

On accept of a legal pattern for digit k:
- shadow nibble k <= decoded value.
- cap_mask_o[k] <= 1.
- Re-accepting digit k in the same frame overwrites the nibble (last wins).

On accept of an illegal pattern:
- Next cycle: err_o=1, cap_mask_o <= 0.
- value_o holds; no valid_o.

Frame complete:
- Occurs in the cycle after the accept that makes cap_mask_o all ones. That cycle: valid_o=1, value_o <= shadow including the just-accepted nibble, cap_mask_o <= 0.
- Digits may arrive in any order.
- Latency: valid_o and value_o update one cycle after the completing accept, so the earliest is STABLE_CYCLES+1 edges after the last digit's pattern first appears.

Output timing:
- valid_o and err_o are never asserted together and never wider than one cycle.
- Accepts are at least STABLE_CYCLES apart, so no two accepts can collide.

Width rules:
- Nibble k occupies value_o[4k+3:4k].
- Counter width is clog2(STABLE_CYCLES+1).

Test Plan:
1. DIGITS=4, STABLE_CYCLES=4; scan sel 0001/0010/0100/1000 with 6F/07/4F/06, 6 cycles each -> single valid_o pulse, value_o=16'h1379, cap_mask_o returns to 0, err_o never high.
2. Hold sel=0001, seg=3F for only 3 cycles, then change seg to 06 for 4 cycles -> exactly one accept (digit 1 into nibble 0), cap_mask_o=0001.
3. Mid-frame, digit 2 shows seg=77 for 4 cycles -> err_o pulses once, cap_mask_o=0, value_o keeps the prior word; a following clean scan produces a fresh valid_o.
4. dig_sel_i=0000 or 0011 held for 20 cycles with seg=7F -> no accept, no valid_o/err_o, cap_mask_o unchanged.
5. Full scan of 00/00/5B/7D (digits 0..3) -> value_o=16'h6200 (blanks decode to 0); a second identical scan gives a second valid_o with the same value.
6. Assert rst for one cycle after 3 digits captured -> all outputs 0 next cycle; completing only the 4th digit afterwards produces no valid_o.
